// File: rtl/sda_kernel_ctrl_pkg.sv
// Shared register map, CTRL bit positions and go/done state encodings
// for the SDA kernel control register block.
package sda_kernel_ctrl_pkg;

  localparam int unsigned CtrlOffset    = 'h00;
  localparam int unsigned GieOffset     = 'h04;
  localparam int unsigned IerOffset     = 'h08;
  localparam int unsigned IsrOffset     = 'h0C;
  localparam int unsigned ArgBaseOffset = 'h10;

  localparam int unsigned CtrlApStartBit     = 0;
  localparam int unsigned CtrlApDoneBit      = 1;
  localparam int unsigned CtrlApIdleBit      = 2;
  localparam int unsigned CtrlApReadyBit     = 3;
  localparam int unsigned CtrlAutoRestartBit = 7;

  localparam logic [1:0] RespOkay = 2'b00;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Start = 2'd1,
    Run   = 2'd2
  } kernelState_e;

  function automatic int unsigned argOffset(input int unsigned n);
    return ArgBaseOffset + 4 * n;
  endfunction

endpackage

// File: rtl/sda_axi_lite_slave_if.sv
// AXI4-Lite handshake front end: holds AW/W until both arrive, then issues a
// one-cycle write strobe; reads are strobed at AR acceptance and registered.
module sda_axi_lite_slave_if
  import sda_kernel_ctrl_pkg::*;
#(
  parameter int AddrWidth = 6
) (
  input  logic                 clk,
  input  logic                 sysRst,
  input  logic [AddrWidth-1:0] s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [AddrWidth-1:0] s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic                 wrEn,
  output logic [AddrWidth-3:0] wrAddr,
  output logic [31:0]          wrData,
  output logic [3:0]           wrStrb,
  output logic                 rdEn,
  output logic [AddrWidth-3:0] rdAddr,
  input  logic [31:0]          rdData
);

  logic                 resetDone;
  logic                 awHeld;
  logic                 wHeld;
  logic                 bValidQ;
  logic                 rValidQ;
  logic [AddrWidth-3:0] awAddrQ;
  logic [31:0]          wDataQ;
  logic [3:0]           wStrbQ;
  logic [31:0]          rDataQ;
  logic                 awFire;
  logic                 wFire;
  logic                 bFire;
  logic                 arFire;
  logic                 rFire;
  logic                 unusedAddrLow;

  // Byte-lane bits of the address carry no meaning in a word-aligned map.
  assign unusedAddrLow = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Readies stay low for the first cycle after reset so nothing is accepted mid-reset.
  assign s_axi_awready = resetDone & ~awHeld;
  assign s_axi_wready  = resetDone & ~wHeld;
  assign s_axi_arready = resetDone & ~rValidQ;
  assign s_axi_bvalid  = bValidQ;
  assign s_axi_bresp   = RespOkay;
  assign s_axi_rvalid  = rValidQ;
  assign s_axi_rdata   = rDataQ;
  assign s_axi_rresp   = RespOkay;

  assign awFire = s_axi_awvalid & s_axi_awready;
  assign wFire  = s_axi_wvalid & s_axi_wready;
  assign bFire  = bValidQ & s_axi_bready;
  assign arFire = s_axi_arvalid & s_axi_arready;
  assign rFire  = rValidQ & s_axi_rready;

  assign wrEn   = awHeld & wHeld & ~bValidQ;
  assign wrAddr = awAddrQ;
  assign wrData = wDataQ;
  assign wrStrb = wStrbQ;
  assign rdEn   = arFire;
  assign rdAddr = s_axi_araddr[AddrWidth-1:2];

  always_ff @(posedge clk or posedge sysRst) begin
    if (sysRst) begin
      resetDone <= 1'b0;
      awHeld    <= 1'b0;
      wHeld     <= 1'b0;
      bValidQ   <= 1'b0;
      rValidQ   <= 1'b0;
      awAddrQ   <= '0;
      wDataQ    <= '0;
      wStrbQ    <= '0;
      rDataQ    <= '0;
    end else begin
      resetDone <= 1'b1;
      if (bFire) begin
        awHeld  <= 1'b0;
        wHeld   <= 1'b0;
        bValidQ <= 1'b0;
      end else begin
        if (awFire) begin
          awHeld  <= 1'b1;
          awAddrQ <= s_axi_awaddr[AddrWidth-1:2];
        end
        if (wFire) begin
          wHeld  <= 1'b1;
          wDataQ <= s_axi_wdata;
          wStrbQ <= s_axi_wstrb;
        end
        if (wrEn) bValidQ <= 1'b1;
      end
      if (arFire) begin
        rValidQ <= 1'b1;
        rDataQ  <= rdData;
      end else if (rFire) begin
        rValidQ <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sda_kernel_control_regs.sv
// Host-side kernel control registers (CTRL/GIE/IER/ISR/ARGn) and go/done FSM.
// Define SDA_KERNEL_CTRL_AUTO_RESTART_EN to enable CTRL bit7 auto restart.
module sda_kernel_control_regs
  import sda_kernel_ctrl_pkg::*;
#(
  parameter int AddrWidth = 6,
  parameter int ArgCount  = 4
) (
  input  logic                  clk,
  input  logic                  sysRst,
  input  logic [AddrWidth-1:0]  s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [AddrWidth-1:0]  s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  regGoValid,
  input  logic                  regGoHoldoff,
  input  logic                  regDoneValid,
  output logic                  regDoneStop,
  output logic [32*ArgCount-1:0] kernelArgs,
  output logic                  interrupt
);

  localparam int WordW = AddrWidth - 2;

  logic             wrEn;
  logic             rdEn;
  logic [WordW-1:0] wrAddr;
  logic [WordW-1:0] rdAddr;
  logic [31:0]      wrData;
  logic [31:0]      rdData;
  logic [3:0]       wrStrb;

  kernelState_e     state;
  kernelState_e     stateNext;
  logic             apStart;
  logic             apDone;
  logic             apReady;
  logic             apIdle;
  logic             autoRestart;
  logic             gie;
  logic             irq;
  logic [1:0]       ier;
  logic [1:0]       isr;
  logic [1:0]       isrNext;
  logic [31:0]      args [ArgCount];
  logic [ArgCount-1:0] argWr;
  logic             ctrlWr;
  logic             gieWr;
  logic             ierWr;
  logic             isrWr;
  logic             ctrlRd;
  logic             goFire;
  logic             doneFire;
  logic             startReq;

  sda_axi_lite_slave_if #(.AddrWidth(AddrWidth)) axiIf (
    .clk           (clk),
    .sysRst        (sysRst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wrEn          (wrEn),
    .wrAddr        (wrAddr),
    .wrData        (wrData),
    .wrStrb        (wrStrb),
    .rdEn          (rdEn),
    .rdAddr        (rdAddr),
    .rdData        (rdData)
  );

  // Control registers occupy byte lane 0 only.
  assign ctrlWr = wrEn & wrStrb[0] & (wrAddr == WordW'(CtrlOffset >> 2));
  assign gieWr  = wrEn & wrStrb[0] & (wrAddr == WordW'(GieOffset >> 2));
  assign ierWr  = wrEn & wrStrb[0] & (wrAddr == WordW'(IerOffset >> 2));
  assign isrWr  = wrEn & wrStrb[0] & (wrAddr == WordW'(IsrOffset >> 2));
  assign ctrlRd = rdEn & (rdAddr == WordW'(CtrlOffset >> 2));

  assign regGoValid  = (state == Start);
  assign regDoneStop = (state != Run);
  assign apIdle      = (state == Idle);
  assign goFire      = regGoValid & ~regGoHoldoff;
  assign doneFire    = regDoneValid & ~regDoneStop;
  assign startReq    = (apIdle & ctrlWr & wrData[CtrlApStartBit]) | (doneFire & autoRestart);
  assign interrupt   = irq;

`ifdef SDA_KERNEL_CTRL_AUTO_RESTART_EN
  always_ff @(posedge clk or posedge sysRst) begin
    if (sysRst) autoRestart <= 1'b0;
    else if (ctrlWr) autoRestart <= wrData[CtrlAutoRestartBit];
  end
`else
  assign autoRestart = 1'b0;
`endif

  always_ff @(posedge clk or posedge sysRst) begin
    if (sysRst) state <= Idle;
    else state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      Idle:    if (ctrlWr && wrData[CtrlApStartBit]) stateNext = Start;
      Start:   if (goFire) stateNext = Run;
      Run:     if (doneFire) stateNext = autoRestart ? Start : Idle;
      default: stateNext = Idle;
    endcase
  end

  // Kernel events are applied after the host toggle so a same-cycle set wins.
  always_comb begin
    isrNext = isr ^ (isrWr ? wrData[1:0] : 2'b00);
    if (goFire && ier[1]) isrNext[1] = 1'b1;
    if (doneFire && ier[0]) isrNext[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge sysRst) begin
    if (sysRst) begin
      apStart <= 1'b0;
      apDone  <= 1'b0;
      apReady <= 1'b0;
      gie     <= 1'b0;
      ier     <= 2'b00;
      isr     <= 2'b00;
      irq     <= 1'b0;
    end else begin
      if (goFire) apStart <= 1'b0;
      else if (startReq) apStart <= 1'b1;
      if (doneFire) apDone <= 1'b1;
      else if (ctrlRd) apDone <= 1'b0;
      if (goFire) apReady <= 1'b1;
      else if (ctrlRd) apReady <= 1'b0;
      if (gieWr) gie <= wrData[0];
      if (ierWr) ier <= wrData[1:0];
      isr <= isrNext;
      irq <= gie & |(isr & ier);
    end
  end

  always_comb begin
    for (int n = 0; n < ArgCount; n++) begin
      argWr[n] = wrEn & (wrAddr == WordW'(argOffset(n) >> 2));
    end
  end

  always_ff @(posedge clk or posedge sysRst) begin
    if (sysRst) begin
      for (int n = 0; n < ArgCount; n++) args[n] <= '0;
    end else begin
      for (int n = 0; n < ArgCount; n++) begin
        for (int b = 0; b < 4; b++) begin
          if (argWr[n] && wrStrb[b]) args[n][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < ArgCount; n++) kernelArgs[32*n +: 32] = args[n];
  end

  // Read mux sees pre-update values, so a read racing an event returns the old state.
  always_comb begin
    rdData = '0;
    if (rdAddr == WordW'(CtrlOffset >> 2)) begin
      rdData[CtrlApStartBit]     = apStart;
      rdData[CtrlApDoneBit]      = apDone;
      rdData[CtrlApIdleBit]      = apIdle;
      rdData[CtrlApReadyBit]     = apReady;
      rdData[CtrlAutoRestartBit] = autoRestart;
    end else if (rdAddr == WordW'(GieOffset >> 2)) begin
      rdData[0] = gie;
    end else if (rdAddr == WordW'(IerOffset >> 2)) begin
      rdData[1:0] = ier;
    end else if (rdAddr == WordW'(IsrOffset >> 2)) begin
      rdData[1:0] = isr;
    end
    for (int n = 0; n < ArgCount; n++) begin
      if (rdAddr == WordW'(argOffset(n) >> 2)) rdData = args[n];
    end
  end

endmodule

// File: tb/tb_sda_kernel_control_regs.sv
// Self-checking bench for sda_kernel_control_regs: register vector table,
// randomized register traffic against a map model, and go/done sequences.
module tb_sda_kernel_control_regs;

  localparam int AddrWidth = 6;
  localparam int ArgCount  = 4;

`ifdef SDA_KERNEL_CTRL_AUTO_RESTART_EN
  localparam logic [31:0] CtrlBit7Exp = 32'h84;
`else
  localparam logic [31:0] CtrlBit7Exp = 32'h04;
`endif

  logic                   clk;
  logic                   sysRst;
  logic [AddrWidth-1:0]   s_axi_awaddr;
  logic                   s_axi_awvalid;
  logic                   s_axi_awready;
  logic [31:0]            s_axi_wdata;
  logic [3:0]             s_axi_wstrb;
  logic                   s_axi_wvalid;
  logic                   s_axi_wready;
  logic [1:0]             s_axi_bresp;
  logic                   s_axi_bvalid;
  logic                   s_axi_bready;
  logic [AddrWidth-1:0]   s_axi_araddr;
  logic                   s_axi_arvalid;
  logic                   s_axi_arready;
  logic [31:0]            s_axi_rdata;
  logic [1:0]             s_axi_rresp;
  logic                   s_axi_rvalid;
  logic                   s_axi_rready;
  logic                   regGoValid;
  logic                   regGoHoldoff;
  logic                   regDoneValid;
  logic                   regDoneStop;
  logic [32*ArgCount-1:0] kernelArgs;
  logic                   interrupt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mArgs [ArgCount];
  bit          mGie;
  bit [1:0]    mIer;
  bit [1:0]    mIsr;

  typedef struct {
    logic [AddrWidth-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           strb;
    logic [31:0]          expRead;
    string                name;
  } vec_t;

  vec_t vecs [14];

  sda_kernel_control_regs #(.AddrWidth(AddrWidth), .ArgCount(ArgCount)) dut (
    .clk           (clk),
    .sysRst        (sysRst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .regGoValid    (regGoValid),
    .regGoHoldoff  (regGoHoldoff),
    .regDoneValid  (regDoneValid),
    .regDoneStop   (regDoneStop),
    .kernelArgs    (kernelArgs),
    .interrupt     (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Full AXI write; AW leads W by awLead cycles. Returns the number of cycles bvalid was seen.
  task automatic applyStimulus(input logic [AddrWidth-1:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int awLead, output int bCount);
    int cyc = 0;
    bit awDone = 0;
    bit wDone = 0;
    bit bDone = 0;
    bCount = 0;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = (awLead == 0);
    s_axi_bready  = 1'b1;
    while (!bDone && cyc < 60) begin
      bit awFire;
      bit wFire;
      bit bFire;
      awFire = s_axi_awvalid && s_axi_awready;
      wFire  = s_axi_wvalid && s_axi_wready;
      bFire  = s_axi_bvalid && s_axi_bready;
      if (s_axi_bvalid) bCount++;
      @(negedge clk);
      cyc++;
      if (awFire) begin awDone = 1; s_axi_awvalid = 1'b0; end
      if (wFire) begin wDone = 1; s_axi_wvalid = 1'b0; end
      if (!wDone && cyc >= awLead) s_axi_wvalid = 1'b1;
      if (bFire) bDone = 1;
    end
    repeat (2) begin
      @(negedge clk);
      if (s_axi_bvalid) bCount++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    checkOutput("writeComplete", 32'(bDone), 32'd1);
  endtask

  // Full AXI read; rready held low holdCycles after rvalid. Optionally pulses done with AR.
  task automatic axiRead(input logic [AddrWidth-1:0] addr, input int holdCycles, input bit pulseDone,
                         output logic [31:0] data, output bit stable);
    int cyc = 0;
    stable = 1;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    while (!s_axi_arready && cyc < 60) begin @(negedge clk); cyc++; end
    if (pulseDone) regDoneValid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    regDoneValid  = 1'b0;
    while (!s_axi_rvalid && cyc < 60) begin @(negedge clk); cyc++; end
    checkOutput("readValid", 32'(s_axi_rvalid), 32'd1);
    data = s_axi_rdata;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      if (!s_axi_rvalid || s_axi_rdata !== data) stable = 0;
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [AddrWidth-1:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bit st;
    axiRead(addr, 0, 1'b0, d, st);
    checkOutput(name, d, exp);
  endtask

  task automatic doReset();
    sysRst = 1'b1;
    repeat (3) @(negedge clk);
    sysRst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < ArgCount; n++) mArgs[n] = '0;
    mGie = 0;
    mIer = '0;
    mIsr = '0;
  endtask

  function automatic logic [31:0] modelRead(input int word);
    if (word == 0) return 32'h4;
    if (word == 1) return {31'b0, mGie};
    if (word == 2) return {30'b0, mIer};
    if (word == 3) return {30'b0, mIsr};
    if (word >= 4 && word < 4 + ArgCount) return mArgs[word-4];
    return 32'h0;
  endfunction

  function automatic void modelWrite(input int word, input logic [31:0] d, input logic [3:0] s);
    if (word == 1 && s[0]) mGie = d[0];
    else if (word == 2 && s[0]) mIer = d[1:0];
    else if (word == 3 && s[0]) mIsr = mIsr ^ d[1:0];
    else if (word >= 4 && word < 4 + ArgCount) begin
      for (int b = 0; b < 4; b++) if (s[b]) mArgs[word-4][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  initial begin
    int bCount;
    logic [31:0] d;
    bit st;

    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
    s_axi_rready = 0; regGoHoldoff = 0; regDoneValid = 0;

    // Reset values, sampled while reset is held.
    sysRst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstAwready", 32'(s_axi_awready), 0);
    checkOutput("rstArready", 32'(s_axi_arready), 0);
    checkOutput("rstBvalid", 32'(s_axi_bvalid), 0);
    checkOutput("rstRvalid", 32'(s_axi_rvalid), 0);
    checkOutput("rstGoValid", 32'(regGoValid), 0);
    checkOutput("rstDoneStop", 32'(regDoneStop), 1);
    checkOutput("rstIrq", 32'(interrupt), 0);
    doReset();
    readCheck("rstCtrl", 6'h00, 32'h4);

    vecs[0]  = '{6'h10, 32'h12345678, 4'hF, 32'h12345678, "arg0Full"};
    vecs[1]  = '{6'h14, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, "arg1Fill"};
    vecs[2]  = '{6'h14, 32'hDEADBEEF, 4'h3, 32'hFFFFBEEF, "arg1Strb"};
    vecs[3]  = '{6'h1C, 32'hAABBCCDD, 4'hA, 32'hAA00CC00, "arg3Strb"};
    vecs[4]  = '{6'h1B, 32'h11223344, 4'hF, 32'h11223344, "arg2LowBits"};
    vecs[5]  = '{6'h04, 32'hFFFFFFFF, 4'hF, 32'h00000001, "gieSet"};
    vecs[6]  = '{6'h04, 32'h00000000, 4'hF, 32'h00000000, "gieClr"};
    vecs[7]  = '{6'h08, 32'hFFFFFFFF, 4'hF, 32'h00000003, "ierSet"};
    vecs[8]  = '{6'h0C, 32'h00000003, 4'hF, 32'h00000003, "isrToggle3"};
    vecs[9]  = '{6'h0C, 32'h00000001, 4'hF, 32'h00000002, "isrToggle1"};
    vecs[10] = '{6'h0C, 32'h00000002, 4'hF, 32'h00000000, "isrToggle2"};
    vecs[11] = '{6'h20, 32'hCAFEF00D, 4'hF, 32'h00000000, "unmapped"};
    vecs[12] = '{6'h00, 32'h00000080, 4'hF, CtrlBit7Exp,  "ctrlBit7"};
    vecs[13] = '{6'h08, 32'h00000000, 4'hE, 32'h00000003, "ierNoLane0"};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, bCount);
      readCheck(vecs[i].name, vecs[i].addr, vecs[i].expRead);
    end
    checkOutput("kernelArg0", kernelArgs[31:0], 32'h12345678);
    checkOutput("kernelArg1", kernelArgs[63:32], 32'hFFFFBEEF);
    checkOutput("kernelArg2", kernelArgs[95:64], 32'h11223344);
    checkOutput("kernelArg3", kernelArgs[127:96], 32'hAA00CC00);

    // Random register traffic against the map model, kernel left idle.
    doReset();
    for (int i = 0; i < 60; i++) begin
      int word;
      logic [AddrWidth-1:0] a;
      logic [31:0] wd;
      logic [3:0] ws;
      word = $urandom_range(0, 15);
      a = AddrWidth'(word * 4 + $urandom_range(0, 3));
      if (word != 0 && $urandom_range(0, 1) == 1) begin
        wd = $urandom;
        ws = 4'($urandom_range(0, 15));
        applyStimulus(a, wd, ws, $urandom_range(0, 2), bCount);
        modelWrite(word, wd, ws);
        checkOutput("randIrq", 32'(interrupt), 32'(mGie & (|(mIsr & mIer))));
        if (word >= 4 && word < 4 + ArgCount)
          checkOutput("randKernelArg", kernelArgs[32*(word-4) +: 32], mArgs[word-4]);
      end else begin
        axiRead(a, $urandom_range(0, 2), 1'b0, d, st);
        checkOutput("randRead", d, modelRead(word));
      end
    end

    // Go handshake held off for five cycles.
    doReset();
    regGoHoldoff = 1'b1;
    applyStimulus(6'h00, 32'h1, 4'hF, 0, bCount);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("goHeld", 32'(regGoValid), 1);
    end
    readCheck("ctrlInStart", 6'h00, 32'h1);
    regGoHoldoff = 1'b0;
    @(negedge clk);
    checkOutput("goDropped", 32'(regGoValid), 0);
    checkOutput("doneStopRun", 32'(regDoneStop), 0);
    readCheck("ctrlReady", 6'h00, 32'h8);
    readCheck("ctrlReadyCleared", 6'h00, 32'h0);
    applyStimulus(6'h00, 32'h1, 4'hF, 0, bCount);
    checkOutput("startIgnoredGo", 32'(regGoValid), 0);
    readCheck("startIgnoredCtrl", 6'h00, 32'h0);

    // Done completion raises ap_done, ISR[0] and, a cycle later, the interrupt.
    applyStimulus(6'h04, 32'h1, 4'hF, 0, bCount);
    applyStimulus(6'h08, 32'h1, 4'hF, 0, bCount);
    regDoneValid = 1'b1;
    @(negedge clk);
    regDoneValid = 1'b0;
    checkOutput("irqNotYet", 32'(interrupt), 0);
    checkOutput("doneStopIdle", 32'(regDoneStop), 1);
    @(negedge clk);
    checkOutput("irqRaised", 32'(interrupt), 1);
    readCheck("ctrlDone", 6'h00, 32'h6);
    readCheck("ctrlDoneCleared", 6'h00, 32'h4);
    readCheck("isrDone", 6'h0C, 32'h1);
    applyStimulus(6'h0C, 32'h1, 4'hF, 0, bCount);
    checkOutput("irqCleared", 32'(interrupt), 0);

    // AW three cycles ahead of W gives one update; a stalled read keeps rdata steady.
    applyStimulus(6'h0C, 32'h1, 4'hF, 3, bCount);
    checkOutput("singleB", 32'(bCount), 1);
    axiRead(6'h0C, 4, 1'b0, d, st);
    checkOutput("isrSingleToggle", d, 32'h1);
    checkOutput("rdataStable", 32'(st), 1);
    checkOutput("rvalidDropped", 32'(s_axi_rvalid), 0);

    // Done arriving with a CTRL read: read sees the old value, the set survives.
    applyStimulus(6'h00, 32'h1, 4'hF, 0, bCount);
    checkOutput("runDoneStop", 32'(regDoneStop), 0);
    readCheck("ctrlRun", 6'h00, 32'h8);
    axiRead(6'h00, 0, 1'b1, d, st);
    checkOutput("raceReadOld", d, 32'h0);
    readCheck("raceSetWins", 6'h00, 32'h6);
    readCheck("raceCleared", 6'h00, 32'h4);

    // Reset while running returns everything to idle immediately.
    applyStimulus(6'h00, 32'h1, 4'hF, 0, bCount);
    checkOutput("preRstDoneStop", 32'(regDoneStop), 0);
    checkOutput("preRstIrq", 32'(interrupt), 1);
    sysRst = 1'b1;
    #1;
    checkOutput("midRstGoValid", 32'(regGoValid), 0);
    checkOutput("midRstDoneStop", 32'(regDoneStop), 1);
    checkOutput("midRstIrq", 32'(interrupt), 0);
    @(negedge clk);
    doReset();
    readCheck("postRstCtrl", 6'h00, 32'h4);
    readCheck("postRstIsr", 6'h0C, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
